mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 start  input  1  start-multiply request (decoded mult/multu).
REQ-006 mult_sign  input  1  1 = signed two's-complement, 0 = unsigned; sampled with start.
REQ-007 src_a  input  WIDTH  multiplicand, sampled with start.
REQ-008 src_b  input  WIDTH  multiplier, sampled with start.
REQ-009 hilo_read  input  1  current instruction reads HI or LO (mfhi/mflo).
REQ-010 busy  output  1  multiply in progress.
REQ-011 stall  output  1  pipeline hold request.
REQ-012 done  output  1  one-cycle pulse; hi/lo just updated.
REQ-013 hi  output  WIDTH  upper half of the last completed product.
REQ-014 lo  output  WIDTH  lower half of the last completed product.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, FIX; busy SHALL be 1 exactly when state != IDLE.
REQ-016 In IDLE with start=1, the block SHALL latch the operands and sign mode and enter RUN. With mult_sign=1 it SHALL latch the magnitudes of src_a and src_b, plus neg = sign(a) XOR sign(b). With mult_sign=0 it SHALL set neg=0.
REQ-017 RUN SHALL perform one shift-add step per cycle for exactly WIDTH cycles, counted by an internal counter 0..WIDTH-1, then go to FIX.
REQ-018 Accumulation SHALL use a 2*WIDTH-bit unsigned product register with a WIDTH+1-bit adder carry; no product bits SHALL be lost.
REQ-019 Magnitude of the most-negative value (0x80000000 at WIDTH=32) SHALL be 2^(WIDTH-1), handled as unsigned without overflow.
REQ-020 FIX SHALL last one cycle and write {hi,lo} = neg ? two's-complement negation of the 2*WIDTH-bit product : product, then return to IDLE.
REQ-021 done SHALL be registered, high for exactly the one cycle after FIX, coincident with the new hi/lo values and busy=0.
REQ-022 Latency SHALL be fixed: start accepted in cycle 0, busy in cycles 1..WIDTH+1, done and new hi/lo in cycle WIDTH+2 (cycle 34 at WIDTH=32).
REQ-023 hi/lo SHALL hold their previous values throughout RUN and FIX, changing only on the FIX edge.
REQ-024 start while busy=1 SHALL be ignored: no restart, no change to latched operands.
REQ-025 start in the done cycle (state IDLE) SHALL be accepted normally, giving back-to-back operation.
REQ-026 stall SHALL be combinational: stall = hilo_read AND (busy OR start).
REQ-027 With hilo_read=1 and start=1 in the same cycle, stall SHALL be 1 and the multiply SHALL still be accepted.
REQ-028 stall SHALL be 0 in the done cycle unless start=1.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear the counter, product and neg registers, and drive hi=0, lo=0, done=0, busy=0.
REQ-030 Reset SHALL take priority over start and SHALL abort any multiply in progress; no done pulse and no hi/lo update SHALL follow.
REQ-031 stall SHALL be 0 during reset unless hilo_read and start are both 1; being combinational, it follows REQ-026.

Verification
REQ-032 Unsigned, a=3, b=5, start at cycle 0 -> busy in cycles 1..33; done=1 in cycle 34; hi=0, lo=15.
REQ-033 Unsigned, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Signed, same operands -> hi=0, lo=1.
REQ-034 Signed, a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Signed, a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-035 During busy: hilo_read=1 -> stall=1. A second start with different operands -> ignored; the first result is delivered at cycle 34. hi/lo hold their prior values until done.
REQ-036 rst_n=0 at cycle 10 of a multiply -> next cycle busy=0, hi=lo=0; no done pulse in any later cycle. A new start after reset completes with a correct result.

Source files
------------

// File: rtl/mult_sequencer.sv
// Sequential shift-add multiplier for a MIPS-style HI/LO unit.
// A start request latches operand magnitudes and the sign of the result.
// RUN then performs WIDTH shift-add steps, one per cycle.
// FIX applies the sign correction and writes HI/LO, and done pulses the cycle after.
// stall holds the pipeline when an mfhi/mflo would read a stale result.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_read,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1)
    // as an unsigned number, which fits because the result is kept unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                    input logic             signed_mode);
        logic [WIDTH-1:0] mag;
        if (signed_mode && value[WIDTH-1]) begin
            mag = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    // Two's-complement negation of the full double-width product.
    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] value);
        return ~value + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] product_r;
    logic               neg_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               last_step_s;
    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] product_next_s;
    logic [2*WIDTH-1:0] result_s;

    assign last_step_s = (count_r == LAST_COUNT);

    // Next-state decode: a start is only honoured from IDLE, so requests
    // arriving while busy are dropped without touching the latched operands.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // One shift-add step: the upper half plus the conditional addend is
    // computed WIDTH+1 bits wide so the carry shifts into the product.
    // The multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        addend_s       = {(WIDTH+1){1'b0}};
        sum_s          = {(WIDTH+1){1'b0}};
        product_next_s = {(2*WIDTH){1'b0}};
        if (product_r[0]) begin
            addend_s = {1'b0, mcand_r};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end
        sum_s          = {1'b0, product_r[2*WIDTH-1:WIDTH]} + addend_s;
        product_next_s = {sum_s, product_r[WIDTH-1:1]};
    end

    // Sign correction applied in FIX to the unsigned magnitude product.
    always_comb begin
        result_s = product_r;
        if (neg_r) begin
            result_s = negate_wide(product_r);
        end else begin
            result_s = product_r;
        end
    end

    // Datapath: operand capture, iteration, result write-back and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r   <= {CW{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            neg_r     <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == FIX);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r   <= magnitude(src_a, mult_sign);
                        product_r <= {{WIDTH{1'b0}}, magnitude(src_b, mult_sign)};
                        neg_r     <= mult_sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        count_r   <= {CW{1'b0}};
                    end else begin
                        count_r   <= count_r;
                    end
                end
                RUN: begin
                    product_r <= product_next_s;
                    count_r   <= count_r + COUNT_ONE;
                end
                FIX: begin
                    hi_r <= result_s[2*WIDTH-1:WIDTH];
                    lo_r <= result_s[WIDTH-1:0];
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy  = (state_r != IDLE);
    assign stall = hilo_read & (busy | start);
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer at WIDTH=32.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_mult_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mult_sign;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hilo_read;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_hi;
    logic [WIDTH-1:0] exp_lo;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mult_sign (mult_sign),
        .src_a     (src_a),
        .src_b     (src_b),
        .hilo_read (hilo_read),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive a start (cycle 0) and move to cycle 1; operands are then scrambled
    // so that only the values latched with start can matter.
    task automatic start_mult(input logic sgn, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic rd);
        mult_sign = sgn;
        src_a     = a;
        src_b     = b;
        hilo_read = rd;
        start     = 1'b1;
        #1;
        check("stall_at_start", {63'd0, stall}, {63'd0, rd});
        @(posedge clk);
        #1;
        start     = 1'b0;
        hilo_read = 1'b0;
        mult_sign = ~sgn;
        src_a     = $urandom;
        src_b     = $urandom;
    endtask

    // Sample n busy cycles: busy high, no done, hi/lo still the old result.
    task automatic run_busy(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("busy", {63'd0, busy}, 64'd1);
            check("no_done_while_busy", {63'd0, done}, 64'd0);
            check("hilo_hold", {hi, lo}, {exp_hi, exp_lo});
        end
    endtask

    // Sample the done cycle and record the new result as the held value.
    task automatic check_result(input string tag, input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("busy_clear_at_done", {63'd0, busy}, 64'd0);
        check(tag, {hi, lo}, {h, l});
        exp_hi = h;
        exp_lo = l;
    endtask

    initial begin
        int done_seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        mult_sign = 1'b0;
        src_a     = '0;
        src_b     = '0;
        hilo_read = 1'b0;
        exp_hi    = '0;
        exp_lo    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // 3*5 unsigned, with an mfhi stalled mid-run
        start_mult(1'b0, 32'd3, 32'd5, 1'b0);
        run_busy(10);
        hilo_read = 1'b1;
        #1;
        check("stall_during_busy", {63'd0, stall}, 64'd1);
        hilo_read = 1'b0;
        run_busy(23);
        check_result("u_3x5", 32'd0, 32'd15);
        hilo_read = 1'b1;
        #1;
        check("no_stall_in_done", {63'd0, stall}, 64'd0);
        hilo_read = 1'b0;

        // Back-to-back starts in the done cycle
        start_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_busy(33);
        check_result("u_max_sq", 32'hFFFF_FFFE, 32'h0000_0001);
        start_mult(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_busy(33);
        check_result("s_m1_sq", 32'h0000_0000, 32'h0000_0001);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Start together with hilo_read: stalls and is still accepted
        start_mult(1'b1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        run_busy(33);
        check_result("s_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Most-negative operand boundaries
        start_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_busy(33);
        check_result("s_min_sq", 32'h4000_0000, 32'h0000_0000);
        start_mult(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_busy(33);
        check_result("s_max_x_min", 32'hC000_0000, 32'h8000_0000);
        start_mult(1'b0, 32'h8000_0000, 32'd2, 1'b0);
        run_busy(33);
        check_result("u_min_x2", 32'h0000_0001, 32'h0000_0000);

        // A second start while busy is ignored
        start_mult(1'b0, 32'd3, 32'd5, 1'b0);
        run_busy(5);
        mult_sign = 1'b1;
        src_a     = 32'd7;
        src_b     = 32'hFFFF_FFF7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_busy(28);
        check_result("ignored_restart", 32'd0, 32'd15);

        // Reset in cycle 10 of a multiply aborts it
        start_mult(1'b1, 32'hFFFF_FFF0, 32'd7, 1'b0);
        run_busy(10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        start     = 1'b1;
        hilo_read = 1'b1;
        src_a     = 32'd9;
        src_b     = 32'd9;
        #1;
        check("stall_in_reset", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1;
        start     = 1'b0;
        hilo_read = 1'b0;
        rst_n     = 1'b1;
        exp_hi    = '0;
        exp_lo    = '0;
        @(negedge clk);
        check("reset_beats_start", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy || hi != 32'd0 || lo != 32'd0) done_seen++;
        end
        check("no_activity_after_abort", 64'(done_seen), 64'd0);

        // Fresh multiply after reset
        start_mult(1'b0, 32'h1234_5678, 32'h0000_0010, 1'b0);
        run_busy(33);
        check_result("u_after_reset", 32'h0000_0001, 32'h2345_6780);

        // Signed zero times negative: negative sign flag, zero result
        start_mult(1'b1, 32'd0, 32'hFFFF_FFFB, 1'b0);
        run_busy(33);
        check_result("s_zero_x_neg", 32'd0, 32'd0);
        @(negedge clk);
        check("final_idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
